// File: rtl/dmem_request_unit.sv
// MEM-stage data-memory request unit: issues one aligned dmem access per op
// and holds it until dmem_resp, stalling the pipeline meanwhile.
//
// Ports:
//   clk, rst (async, active-low)
//   start, is_store, funct3, addr, rs2_data : op from the EX/MEM buffer
//   dmem_address, dmem_read, dmem_write,
//   dmem_wmask, dmem_wdata                  : registered memory request
//   dmem_resp, dmem_rdata                   : memory completion
//   mdr, mar                                : latched read word / byte address
//   stall, done, misaligned                 : pipeline control
module dmem_request_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] dmem_address,
    output logic            dmem_read,
    output logic            dmem_write,
    output logic [3:0]      dmem_wmask,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_resp,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] mdr,
    output logic [XLEN-1:0] mar,
    output logic            stall,
    output logic            done,
    output logic            misaligned
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;

    logic            code_ok;
    logic            align_bad;
    logic            accept;
    logic [3:0]      st_wmask;
    logic [XLEN-1:0] st_wdata;

    always_comb begin
        code_ok = 1'b0;
        if (is_store)
            code_ok = funct3 inside {3'b000, 3'b001, 3'b010};
        else
            code_ok = funct3 inside {3'b000, 3'b001, 3'b010,
                                     3'b100, 3'b101};
    end

    // funct3[1:0] encodes the access size for every legal code
    always_comb begin
        align_bad = 1'b0;
        case (funct3[1:0])
            2'b01:   align_bad = addr[0];
            2'b10:   align_bad = addr[1:0] != 2'b00;
            default: align_bad = 1'b0;
        endcase
    end

    always_comb begin
        st_wmask = 4'b0000;
        st_wdata = '0;
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    st_wmask = 4'b0001 << addr[1:0];
                    st_wdata = {4{rs2_data[7:0]}};
                end
                2'b01: begin
                    st_wmask = 4'b0011 << addr[1:0];
                    st_wdata = {2{rs2_data[15:0]}};
                end
                default: begin
                    st_wmask = 4'b1111;
                    st_wdata = rs2_data;
                end
            endcase
        end
    end

    logic idle_op;
    assign idle_op    = start && (state == IDLE) && code_ok;
    assign misaligned = idle_op && align_bad;
    assign accept     = idle_op && !align_bad;
    assign stall      = accept || (state == BUSY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            dmem_address <= '0;
            dmem_read    <= 1'b0;
            dmem_write   <= 1'b0;
            dmem_wmask   <= 4'b0000;
            dmem_wdata   <= '0;
            mdr          <= '0;
            mar          <= '0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        mar          <= addr;
                        dmem_address <= {addr[XLEN-1:2], 2'b00};
                        dmem_wmask   <= st_wmask;
                        dmem_wdata   <= st_wdata;
                        dmem_read    <= !is_store;
                        dmem_write   <= is_store;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (dmem_resp) begin
                        if (dmem_read)
                            mdr <= dmem_rdata;
                        dmem_read  <= 1'b0;
                        dmem_write <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    // start still shows the retiring op here
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_request_unit.sv
// Testbench for dmem_request_unit: vector table, hand-written corner
// sequences and random ops against an arithmetic reference model.
module tb_dmem_request_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] rs2_data;
    logic [31:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;
    logic [31:0] mdr;
    logic [31:0] mar;
    logic        stall;
    logic        done;
    logic        misaligned;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_mdr = '0;
    logic [31:0] exp_mar = '0;

    always #5 clk = ~clk;

    dmem_request_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store),
        .funct3(funct3), .addr(addr), .rs2_data(rs2_data),
        .dmem_address(dmem_address), .dmem_read(dmem_read),
        .dmem_write(dmem_write), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_resp(dmem_resp),
        .dmem_rdata(dmem_rdata), .mdr(mdr), .mar(mar),
        .stall(stall), .done(done), .misaligned(misaligned)
    );

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          waits;
        logic        exp_req;
        logic        exp_mis;
        logic [3:0]  exp_mask;
        logic [31:0] exp_wdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Expected behaviour from access size and byte offset arithmetic
    function automatic vec_t model(input logic st, input logic [2:0] f3,
                                   input logic [31:0] a,
                                   input logic [31:0] rs2,
                                   input logic [31:0] rdata,
                                   input int w);
        vec_t v;
        bit ok;
        int sz;
        int off;
        v.st = st; v.f3 = f3; v.a = a; v.rs2 = rs2;
        v.rdata = rdata; v.waits = w;
        if (st) ok = (f3 <= 3'd2);
        else    ok = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        sz  = 1 << int'(f3[1:0]);
        off = int'(a[1:0]);
        v.exp_mis = ok && ((off % sz) != 0);
        v.exp_req = ok && !v.exp_mis;
        v.exp_mask = 4'b0000;
        if (st && v.exp_req)
            v.exp_mask = 4'(((1 << sz) - 1) << off);
        if (sz == 1)
            v.exp_wdata = {24'b0, rs2[7:0]} * 32'h0101_0101;
        else if (sz == 2)
            v.exp_wdata = {16'b0, rs2[15:0]} * 32'h0001_0001;
        else
            v.exp_wdata = rs2;
        return v;
    endfunction

    // Drives one op from the next posedge; ends in the DONE cycle (start
    // still high) for accepted ops, or one idle cycle later otherwise.
    task automatic run_op(input vec_t v);
        int sc;
        @(posedge clk); #1;
        start = 1'b1; is_store = v.st; funct3 = v.f3;
        addr = v.a; rs2_data = v.rs2; dmem_resp = 1'b0;
        @(negedge clk);
        chk("accept_mis", 32'(misaligned), 32'(v.exp_mis));
        chk("accept_stall", 32'(stall), 32'(v.exp_req));
        chk("accept_done", 32'(done), 0);
        if (!v.exp_req) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk("noreq_read", 32'(dmem_read), 0);
            chk("noreq_write", 32'(dmem_write), 0);
            chk("noreq_stall", 32'(stall), 0);
            chk("noreq_mar", mar, exp_mar);
            return;
        end
        exp_mar = v.a;
        sc = 1;
        for (int k = 0; k <= v.waits; k++) begin
            @(posedge clk); #1;
            dmem_resp  = (k == v.waits);
            dmem_rdata = (k == v.waits) ? v.rdata : $urandom;
            @(negedge clk);
            if (stall) sc++;
            chk("busy_done", 32'(done), 0);
            chk("busy_addr", dmem_address, {v.a[31:2], 2'b00});
            chk("busy_read", 32'(dmem_read), 32'(!v.st));
            chk("busy_write", 32'(dmem_write), 32'(v.st));
            chk("busy_mask", 32'(dmem_wmask), 32'(v.exp_mask));
            if (v.st) chk("busy_wdata", dmem_wdata, v.exp_wdata);
        end
        if (!v.st) exp_mdr = v.rdata;
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        @(negedge clk);
        chk("stall_cycles", sc, v.waits + 2);
        chk("done_pulse", 32'(done), 1);
        chk("done_stall", 32'(stall), 0);
        chk("done_rw", {30'b0, dmem_read, dmem_write}, 0);
        chk("done_mdr", mdr, exp_mdr);
        chk("done_mar", mar, exp_mar);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("idle_done", 32'(done), 0);
        chk("idle_stall", 32'(stall), 0);
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        rst = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b0;
        addr = '0; rs2_data = '0; dmem_resp = 1'b0; dmem_rdata = '0;

        tbl.push_back('{1, 3'b000, 32'h1003, 32'hAABBCCDD, 32'h0, 0,
                        1, 0, 4'b1000, 32'hDDDDDDDD});
        tbl.push_back('{1, 3'b001, 32'h2002, 32'h00001234, 32'h0, 1,
                        1, 0, 4'b1100, 32'h12341234});
        tbl.push_back('{1, 3'b010, 32'h3000, 32'hCAFEF00D, 32'h0, 3,
                        1, 0, 4'b1111, 32'hCAFEF00D});
        tbl.push_back('{0, 3'b100, 32'h4001, 32'h0, 32'h11223344, 0,
                        1, 0, 4'b0000, 32'h0});
        tbl.push_back('{0, 3'b010, 32'h5002, 32'h0, 32'h55555555, 0,
                        0, 1, 4'b0000, 32'h0});
        tbl.push_back('{1, 3'b001, 32'h2001, 32'h0000BEEF, 32'h0, 0,
                        0, 1, 4'b0000, 32'h0});
        tbl.push_back('{1, 3'b101, 32'h0001, 32'h12345678, 32'h0, 0,
                        0, 0, 4'b0000, 32'h0});
        tbl.push_back('{0, 3'b001, 32'h6002, 32'h0, 32'h89ABCDEF, 2,
                        1, 0, 4'b0000, 32'h0});
        tbl.push_back('{0, 3'b101, 32'h6003, 32'h0, 32'h0, 0,
                        0, 1, 4'b0000, 32'h0});
        tbl.push_back('{1, 3'b000, 32'h7001, 32'h000000A5, 32'h0, 1,
                        1, 0, 4'b0010, 32'hA5A5A5A5});

        // reset state
        @(negedge clk); @(negedge clk);
        chk("rst_out", {28'b0, dmem_read, dmem_write, done, stall}, 0);
        chk("rst_mask", 32'(dmem_wmask), 0);
        chk("rst_addr", dmem_address, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_mdr", mdr, 0);
        chk("rst_mar", mar, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        foreach (tbl[i]) begin
            run_op(tbl[i]);
            idle_cycle();
        end

        // spurious response in IDLE after a misaligned lw
        run_op(model(1'b0, 3'b010, 32'h5002, 32'h0, 32'h0, 0));
        @(posedge clk); #1;
        dmem_resp = 1'b1; dmem_rdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        @(negedge clk);
        chk("spur_mdr", mdr, exp_mdr);
        chk("spur_stall", 32'(stall), 0);
        chk("spur_done", 32'(done), 0);

        // back-to-back: next op accepted in the cycle after DONE
        run_op(model(1'b0, 3'b010, 32'h8000, 32'h0, 32'h0BADF00D, 0));
        run_op(model(1'b1, 3'b001, 32'h8006, 32'h0000CAFE, 32'h0, 0));
        idle_cycle();

        // reset during BUSY drops the request asynchronously
        @(posedge clk); #1;
        start = 1'b1; is_store = 1'b1; funct3 = 3'b010;
        addr = 32'h9000; rs2_data = 32'h01020304;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_write_pre", 32'(dmem_write), 1);
        #1 rst = 1'b0; start = 1'b0;
        #1;
        chk("mid_write_drop", 32'(dmem_write), 0);
        chk("mid_stall", 32'(stall), 0);
        chk("mid_mar", mar, 0);
        exp_mar = '0; exp_mdr = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        idle_cycle();

        // random ops against the model
        for (int n = 0; n < 60; n++) begin
            logic [31:0] ra;
            ra = $urandom;
            if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
            v = model(1'($urandom), 3'($urandom), ra, $urandom,
                      $urandom, int'($urandom_range(0, 3)));
            run_op(v);
            if ($urandom_range(0, 1) == 0) idle_cycle();
        end
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
